// File: rtl/seq_dual_converter_cgrundey.sv
// Sequential 10-bit binary <-> 3-digit packed BCD converter.
// mode=0: binary-to-BCD (shift-and-add-3), mode=1: BCD-to-binary
// (shift-and-subtract-3). Each conversion takes 10 SHIFT cycles.
// Optional operand range checking is enabled by defining CONV_ERR_CHECK_EN.
module seq_dual_converter_cgrundey (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [11:0] din,
  output logic [11:0] dout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        mode_r;
  logic [21:0] scratch, scratch_nx;
  logic        operand_ok;
`ifdef CONV_ERR_CHECK_EN
  logic        err_r;
`endif

  // Operand validity of the live inputs, evaluated when start is sampled
  always_comb begin
    operand_ok = 1'b1;
`ifdef CONV_ERR_CHECK_EN
    if (mode)
      operand_ok = (din[11:8] <= 4'd9) && (din[7:4] <= 4'd9) && (din[3:0] <= 4'd9);
    else
      operand_ok = (din[9:0] <= 10'd999);
`endif
  end

  // One algorithm iteration on the scratch register ({bcd[11:0], bin[9:0]})
  always_comb begin
    scratch_nx = scratch;
    if (!mode_r) begin
      for (int unsigned d = 0; d < 3; d++) begin
        if (scratch_nx[10 + 4*d +: 4] >= 4'd5)
          scratch_nx[10 + 4*d +: 4] = scratch_nx[10 + 4*d +: 4] + 4'd3;
      end
      scratch_nx = {scratch_nx[20:0], 1'b0};
    end else begin
      scratch_nx = {1'b0, scratch[21:1]};
      for (int unsigned d = 0; d < 3; d++) begin
        if (scratch_nx[10 + 4*d +: 4] >= 4'd8)
          scratch_nx[10 + 4*d +: 4] = scratch_nx[10 + 4*d +: 4] - 4'd3;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start)
          state_nx = operand_ok ? SHIFT : DONE;
        else if (state == DONE)
          state_nx = IDLE;
      end
      SHIFT:   if (cnt == 4'd9) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // State, operand capture, iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_r  <= 1'b0;
      scratch <= '0;
      dout    <= '0;
`ifdef CONV_ERR_CHECK_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mode_r <= mode;
            cnt    <= '0;
            if (operand_ok) begin
              scratch <= mode ? {din, 10'b0} : {12'b0, din[9:0]};
`ifdef CONV_ERR_CHECK_EN
              err_r   <= 1'b0;
`endif
            end else begin
              dout  <= '0;
`ifdef CONV_ERR_CHECK_EN
              err_r <= 1'b1;
`endif
            end
          end
        end
        SHIFT: begin
          scratch <= scratch_nx;
          // Counter saturates at 9; the last iteration's result goes straight to dout
          if (cnt == 4'd9)
            dout <= mode_r ? {2'b00, scratch_nx[9:0]} : scratch_nx[21:10];
          else
            cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
`ifdef CONV_ERR_CHECK_EN
    err  = done & err_r;
`else
    err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_seq_dual_converter_cgrundey.sv
// Directed testbench for seq_dual_converter_cgrundey (table vectors plus
// hand-written multi-cycle sequences). Honours CONV_ERR_CHECK_EN.
module tb_seq_dual_converter_cgrundey;

  logic        clk = 1'b0;
  logic        rst, start, mode;
  logic [11:0] din;
  logic [11:0] dout;
  logic        busy, done, err;

  int unsigned tests = 0;
  int unsigned fails = 0;

  seq_dual_converter_cgrundey dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .din  (din),
    .dout (dout),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [11:0] d;
    logic [11:0] e;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Full valid conversion: start at one negedge, then check cycles T+1..T+12
  task automatic run_vec(input logic m, input logic [11:0] d, input logic [11:0] e);
    @(negedge clk);
    start = 1'b1; mode = m; din = d;
    @(negedge clk);
    start = 1'b0; mode = ~m; din = ~d;
    for (int i = 1; i <= 10; i++) begin
      chk("busy_window", {11'b0, busy}, 12'd1);
      chk("done_early", {11'b0, done}, 12'd0);
      @(negedge clk);
    end
    chk("done_pulse", {11'b0, done}, 12'd1);
    chk("dout", dout, e);
    chk("err_valid", {11'b0, err}, 12'd0);
    chk("busy_at_done", {11'b0, busy}, 12'd0);
    @(negedge clk);
    chk("done_single", {11'b0, done}, 12'd0);
    chk("err_low", {11'b0, err}, 12'd0);
    chk("dout_hold", dout, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, done_at;
    logic [11:0] seen;

    vecs[0]  = '{1'b0, 12'd999,  12'h999};
    vecs[1]  = '{1'b0, 12'd0,    12'h000};
    vecs[2]  = '{1'b0, 12'd1,    12'h001};
    vecs[3]  = '{1'b0, 12'd255,  12'h255};
    vecs[4]  = '{1'b0, 12'd512,  12'h512};
    vecs[5]  = '{1'b0, 12'hC07,  12'h007};
    vecs[6]  = '{1'b1, 12'h255,  12'h0FF};
    vecs[7]  = '{1'b1, 12'h000,  12'h000};
    vecs[8]  = '{1'b1, 12'h999,  12'h3E7};
    vecs[9]  = '{1'b1, 12'h100,  12'h064};
    vecs[10] = '{1'b1, 12'h009,  12'h009};
    vecs[11] = '{1'b1, 12'h510,  12'h1FE};

    rst = 1'b1; start = 1'b0; mode = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_dout", dout, 12'h000);
    chk("rst_busy", {11'b0, busy}, 12'd0);
    chk("rst_done", {11'b0, done}, 12'd0);
    chk("rst_err", {11'b0, err}, 12'd0);

    foreach (vecs[i]) run_vec(vecs[i].m, vecs[i].d, vecs[i].e);

    // Operand capture: start/din toggled while busy must be ignored
    @(negedge clk);
    start = 1'b1; mode = 1'b0; din = 12'd123;
    pulses = 0; done_at = 0; seen = '0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin pulses++; done_at = i; seen = dout; end
      start = (i >= 3 && i <= 6);
      din   = 12'd456;
    end
    start = 1'b0;
    chk("ignore_pulses", pulses[11:0], 12'd1);
    chk("ignore_done_at", done_at[11:0], 12'd11);
    chk("ignore_dout", seen, 12'h123);

    // Reset mid-conversion, with a start presented alongside rst
    @(negedge clk);
    start = 1'b1; mode = 1'b0; din = 12'd500;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    start = 1'b0;
    chk("abort_busy_before", {11'b0, busy}, 12'd1);
    rst = 1'b1; start = 1'b1; din = 12'd77;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", {11'b0, busy}, 12'd0);
    chk("abort_done", {11'b0, done}, 12'd0);
    chk("abort_dout", dout, 12'h000);
    chk("abort_err", {11'b0, err}, 12'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_activity", pulses[11:0], 12'd0);

    // Back-to-back: start held through DONE
    @(negedge clk);
    start = 1'b1; mode = 1'b0; din = 12'd42;
    @(negedge clk);
    for (int i = 1; i <= 10; i++) @(negedge clk);
    chk("b2b_done1", {11'b0, done}, 12'd1);
    chk("b2b_dout1", dout, 12'h042);
    din = 12'd7;
    @(negedge clk);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done) pulses++;
      if (!busy) pulses++;
      @(negedge clk);
    end
    chk("b2b_gap", pulses[11:0], 12'd0);
    chk("b2b_done2", {11'b0, done}, 12'd1);
    chk("b2b_dout2", dout, 12'h007);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done2_single", {11'b0, done}, 12'd0);
    chk("b2b_dout2_hold", dout, 12'h007);

    // Out-of-range operands
`ifdef CONV_ERR_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; mode = (k == 1); din = (k == 1) ? 12'h1A0 : 12'd1000;
      @(negedge clk);
      start = 1'b0;
      chk("inv_done", {11'b0, done}, 12'd1);
      chk("inv_err", {11'b0, err}, 12'd1);
      chk("inv_dout", dout, 12'h000);
      chk("inv_busy", {11'b0, busy}, 12'd0);
      @(negedge clk);
      chk("inv_done_single", {11'b0, done}, 12'd0);
      chk("inv_err_low", {11'b0, err}, 12'd0);
    end
`else
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; mode = (k == 1); din = (k == 1) ? 12'h1A0 : 12'd1000;
      @(negedge clk);
      start = 1'b0;
      pulses = 0; done_at = 0;
      for (int i = 1; i <= 12; i++) begin
        if (err) pulses++;
        if (done && done_at == 0) done_at = i;
        @(negedge clk);
      end
      chk("unchk_err", pulses[11:0], 12'd0);
      chk("unchk_done_at", done_at[11:0], 12'd11);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
